control_unit: RTL
=================

Name: control_unit

Overview:
- Multi-cycle LEGv8 instruction controller. It is the producer side of the 31-bit control-word interface into the register/ALU/RAM datapath.
- Latches the fetched instruction, decodes it, and drives the control word and the 64-bit constant K every cycle.
- Consumes the datapath's 5-bit status bus to resolve conditional branches.
- Instruction memory is addressed by the datapath PC; this block only sees the instruction word.

Parameters:
- LOAD_CYCLES, 1, extra cycles LDUR waits after address issue before writeback (1..3).

Ports:
- clock  input  1  single system clock, rising edge
- reset  input  1  synchronous, active-high reset
- instruction  input  32  instruction word at current PC
- status  input  5  {V, C, Z, N, Zlive}; bits 4:1 registered flags, bit 0 live ALU zero
- controlWord  output  31  {PS[1:0], DA[4:0], SA[4:0], SB[4:0], FS[4:0], regW, ramW, EN_MEM, EN_ALU, EN_B, EN_PC, selB, PCsel, SL}
- K  output  64  immediate / branch offset, sign- or zero-extended
- halted  output  1  high in HALT state
- illegal  output  1  one-cycle pulse on undecodable opcode

Behaviour:
- PS encoding: 00 hold, 01 PC+4, 10 PC<=in, 11 PC<=PC+(in<<2).
- Register 31 reads as zero (XZR). X30 is the link register.
- Reset: state=FETCH, IR=0, controlWord=0, K=0, halted=0, illegal=0. Reset mid-instruction aborts it; no regW/ramW is asserted in the reset cycle or the cycle after.
- FETCH (1 cycle): IR<=instruction; controlWord=0 (PS=00, no writes, no bus enable); goes to EXEC.
- EXEC: outputs are combinational from IR (plus status for CBZ/CBNZ). Exactly one EN_* high or none; the bus is never multiply driven.
  - R-type ADD/SUB/AND/ORR/EOR: DA=Rd, SA=Rn, SB=Rm, FS per op, regW=1, EN_ALU=1, PS=01.
  - ADDS/SUBS: same as above with SL=1.
  - LSL/LSR: SA=Rn, selB=1, K=zero-ext shamt, FS shift, regW=1, EN_ALU=1, PS=01.
  - I-type ADDI/SUBI/ANDI/ORRI/EORI: selB=1, K=zero-ext imm12, DA=Rd, SA=Rn, regW=1, EN_ALU=1, PS=01.
  - STUR: SA=Rn, SB=Rt, selB=1, K=sext imm9, FS=ADD, ramW=1, PS=01; goes to FETCH.
  - LDUR: SA=Rn, selB=1, K=sext imm9, FS=ADD, PS=00; goes to LOAD_WAIT for LOAD_CYCLES-1 cycles, then WB.
  - B: PCsel=1, K=sext imm26, PS=11.
  - BL: as B, plus DA=30, EN_PC=1, regW=1.
  - BR: SA=Rn, PCsel=0, PS=10.
  - CBZ/CBNZ: SA=31, SB=Rt, FS=OR, K=sext imm19, PCsel=1. PS=11 if (status[0]==1) for CBZ or (status[0]==0) for CBNZ; otherwise PS=01.
  - All other states go to FETCH after EXEC.
- LOAD_WAIT / WB: ALU fields held from EXEC (same SA/selB/K/FS). WB adds DA=Rt, EN_MEM=1, regW=1, PS=01, then goes to FETCH.
- Undecodable opcode: illegal pulses for 1 cycle, controlWord=0, go to HALT.
- HALT: controlWord=0, halted=1. Only reset exits HALT.
- Latency: 2 cycles per instruction; LDUR takes 2+LOAD_CYCLES cycles.

Optional Feature:
- Macro: CONTROL_UNIT_BCOND_EN.
- Defined: B.cond (opcode 01010100) is evaluated against status[4:1] for EQ, NE, HS, LO, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL. If true: PCsel=1, K=sext imm19, PS=11; else PS=01.
- Undefined: B.cond is decoded as illegal (HALT).

Decomposition:
- Package legv8_pkg holds:
  - opcode constants;
  - FS codes: AND=00000, OR=00100, ADD=01000, SUB=01011, XOR=01100, LSR=10000, LSL=10100;
  - PS codes;
  - state enum {FETCH, EXEC, LOAD_WAIT, WB, HALT};
  - control-word field offsets.
- One sub-module: cond_eval (4-bit cond + NZCV -> taken), instantiated only under CONTROL_UNIT_BCOND_EN.

Test Plan:
- Reset, then instruction=0x8B030041 (ADD X1,X2,X3). Cycle 1: controlWord=0. Cycle 2: PS=01, DA=1, SA=2, SB=3, FS=01000, regW=1, EN_ALU=1, all else 0.
- 0xF84080C5 (LDUR X5,[X6,#8]), LOAD_CYCLES=1. EXEC: SA=6, selB=1, K=8, FS=ADD, regW=0, PS=00. WB: DA=5, EN_MEM=1, regW=1, PS=01. Then FETCH.
- 0xB4000087 (CBZ X7,+4) with status[0]=1 -> PS=11, PCsel=1, K=4. Repeat with status[0]=0 -> PS=01.
- 0x17FFFFFE (B -2) -> K=64'hFFFFFFFFFFFFFFFE, PS=11, regW=0. BL variant 0x97FFFFFE -> additionally DA=30, EN_PC=1, regW=1.
- Reset asserted in the LDUR WB cycle -> next cycle controlWord=0, state FETCH, no regW.
- Illegal word 0xFFFFFFFF -> illegal pulses 1 cycle, halted=1 and held, controlWord=0 until reset. With CONTROL_UNIT_BCOND_EN: 0x54000040 (B.EQ +2) with Z=1 -> PS=11, K=2.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 controller definitions: opcodes, ALU function and PC-select
// codes, controller states, control-word bit offsets and decode helpers.
package legv8_pkg;

    // 11-bit opcodes in instruction[31:21]
    localparam logic [10:0] OP_ADD  = 11'h458;
    localparam logic [10:0] OP_SUB  = 11'h658;
    localparam logic [10:0] OP_AND  = 11'h450;
    localparam logic [10:0] OP_ORR  = 11'h550;
    localparam logic [10:0] OP_EOR  = 11'h650;
    localparam logic [10:0] OP_ADDS = 11'h558;
    localparam logic [10:0] OP_SUBS = 11'h758;
    localparam logic [10:0] OP_LSL  = 11'h69B;
    localparam logic [10:0] OP_LSR  = 11'h69A;
    localparam logic [10:0] OP_STUR = 11'h7C0;
    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_BR   = 11'h6B0;

    localparam logic [9:0]  OP_ADDI = 10'h244;
    localparam logic [9:0]  OP_SUBI = 10'h344;
    localparam logic [9:0]  OP_ANDI = 10'h248;
    localparam logic [9:0]  OP_ORRI = 10'h2C8;
    localparam logic [9:0]  OP_EORI = 10'h348;

    localparam logic [7:0]  OP_CBZ   = 8'hB4;
    localparam logic [7:0]  OP_CBNZ  = 8'hB5;
    localparam logic [7:0]  OP_BCOND = 8'h54;
    localparam logic [5:0]  OP_B     = 6'h05;
    localparam logic [5:0]  OP_BL    = 6'h25;

    localparam logic [4:0]  FS_AND = 5'b00000;
    localparam logic [4:0]  FS_OR  = 5'b00100;
    localparam logic [4:0]  FS_ADD = 5'b01000;
    localparam logic [4:0]  FS_SUB = 5'b01011;
    localparam logic [4:0]  FS_XOR = 5'b01100;
    localparam logic [4:0]  FS_LSR = 5'b10000;
    localparam logic [4:0]  FS_LSL = 5'b10100;

    localparam logic [1:0]  PS_HOLD = 2'b00;
    localparam logic [1:0]  PS_INC  = 2'b01;
    localparam logic [1:0]  PS_LOAD = 2'b10;
    localparam logic [1:0]  PS_REL  = 2'b11;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        EXEC      = 3'd1,
        LOAD_WAIT = 3'd2,
        WB        = 3'd3,
        HALT      = 3'd4
    } state_t;

    localparam int CW_SL     = 0;
    localparam int CW_PCSEL  = 1;
    localparam int CW_SELB   = 2;
    localparam int CW_EN_PC  = 3;
    localparam int CW_EN_B   = 4;
    localparam int CW_EN_ALU = 5;
    localparam int CW_EN_MEM = 6;
    localparam int CW_RAMW   = 7;
    localparam int CW_REGW   = 8;
    localparam int CW_FS     = 9;
    localparam int CW_SB     = 14;
    localparam int CW_SA     = 19;
    localparam int CW_DA     = 24;
    localparam int CW_PS     = 29;

    function automatic logic [63:0] sext9(input logic [8:0] v);
        return {{55{v[8]}}, v};
    endfunction

    function automatic logic [63:0] sext19(input logic [18:0] v);
        return {{45{v[18]}}, v};
    endfunction

    function automatic logic [63:0] sext26(input logic [25:0] v);
        return {{38{v[25]}}, v};
    endfunction

    function automatic logic [4:0] rtype_fs(input logic [10:0] op);
        logic [4:0] fs;
        case (op)
            OP_SUB, OP_SUBS: fs = FS_SUB;
            OP_AND:          fs = FS_AND;
            OP_ORR:          fs = FS_OR;
            OP_EOR:          fs = FS_XOR;
            default:         fs = FS_ADD;
        endcase
        return fs;
    endfunction

    function automatic logic [4:0] itype_fs(input logic [9:0] op);
        logic [4:0] fs;
        case (op)
            OP_SUBI: fs = FS_SUB;
            OP_ANDI: fs = FS_AND;
            OP_ORRI: fs = FS_OR;
            OP_EORI: fs = FS_XOR;
            default: fs = FS_ADD;
        endcase
        return fs;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// B.cond condition evaluator: 4-bit ARM condition code against NZCV flags.
module cond_eval (
    input  logic [3:0] cond,
    input  logic       n,
    input  logic       z,
    input  logic       c,
    input  logic       v,
    output logic       taken
);
    logic base_s;

    // Odd codes invert the even code's test, except 1111 which stays "always"
    always_comb begin
        base_s = 1'b0;
        case (cond[3:1])
            3'b000:  base_s = z;
            3'b001:  base_s = c;
            3'b010:  base_s = n;
            3'b011:  base_s = v;
            3'b100:  base_s = c & ~z;
            3'b101:  base_s = (n == v);
            3'b110:  base_s = ~z & (n == v);
            default: base_s = 1'b1;
        endcase
        if (cond[0] && (cond[3:1] != 3'b111)) begin
            taken = ~base_s;
        end else begin
            taken = base_s;
        end
    end
endmodule

// File: rtl/control_unit.sv
// LEGv8 multi-cycle controller: latches the instruction, decodes it and drives
// the datapath control word and constant K. B.cond: CONTROL_UNIT_BCOND_EN.
module control_unit #(
    parameter int LOAD_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [4:0]  status,
    output logic [30:0] controlWord,
    output logic [63:0] K,
    output logic        halted,
    output logic        illegal
);
    import legv8_pkg::*;

    state_t      state_r, state_nxt_s;
    logic [31:0] ir_r;
    logic [1:0]  wait_r;
    logic [1:0]  ps_s;
    logic [4:0]  da_s, sa_s, sb_s, fs_s;
    logic        regw_s, ramw_s, en_mem_s, en_alu_s, en_pc_s, selb_s, pcsel_s, sl_s;
    logic        illegal_s;
    logic [63:0] k_s;
    logic [30:0] cw_s;
    logic [10:0] op11_s;
    logic [9:0]  op10_s;
    logic [7:0]  op8_s;
    logic [5:0]  op6_s;
    logic [4:0]  rd_s, rn_s, rm_s;

    assign op11_s = ir_r[31:21];
    assign op10_s = ir_r[31:22];
    assign op8_s  = ir_r[31:24];
    assign op6_s  = ir_r[31:26];
    assign rd_s   = ir_r[4:0];
    assign rn_s   = ir_r[9:5];
    assign rm_s   = ir_r[20:16];

`ifdef CONTROL_UNIT_BCOND_EN
    logic bcond_taken_s;

    cond_eval u_cond_eval (
        .cond  (ir_r[3:0]),
        .n     (status[1]),
        .z     (status[2]),
        .c     (status[3]),
        .v     (status[4]),
        .taken (bcond_taken_s)
    );
`else
    logic unused_flags_s;
    assign unused_flags_s = ^status[4:1];
`endif

    // State, instruction and load-wait registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= FETCH;
            ir_r    <= 32'd0;
            wait_r  <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == FETCH) begin
                ir_r <= instruction;
            end
            if (state_r == LOAD_WAIT) begin
                wait_r <= wait_r + 2'd1;
            end else begin
                wait_r <= 2'd0;
            end
        end
    end

    // Next-state and control-field decode
    always_comb begin
        state_nxt_s = state_r;
        ps_s = PS_HOLD;
        da_s = 5'd0; sa_s = 5'd0; sb_s = 5'd0; fs_s = 5'd0;
        regw_s = 1'b0; ramw_s = 1'b0; en_mem_s = 1'b0; en_alu_s = 1'b0;
        en_pc_s = 1'b0; selb_s = 1'b0; pcsel_s = 1'b0; sl_s = 1'b0;
        k_s = 64'd0;
        illegal_s = 1'b0;
        case (state_r)
            FETCH: state_nxt_s = EXEC;
            EXEC: begin
                state_nxt_s = FETCH;
                if ((op6_s == OP_B) || (op6_s == OP_BL)) begin
                    pcsel_s = 1'b1;
                    k_s     = sext26(ir_r[25:0]);
                    ps_s    = PS_REL;
                    if (op6_s == OP_BL) begin
                        da_s = 5'd30; en_pc_s = 1'b1; regw_s = 1'b1;
                    end else begin
                        regw_s = 1'b0;
                    end
                end else if ((op8_s == OP_CBZ) || (op8_s == OP_CBNZ)) begin
                    sa_s = 5'd31; sb_s = rd_s; fs_s = FS_OR;
                    k_s = sext19(ir_r[23:5]);
                    pcsel_s = 1'b1;
                    ps_s = ((op8_s == OP_CBZ) == status[0]) ? PS_REL : PS_INC;
                end else if (op8_s == OP_BCOND) begin
`ifdef CONTROL_UNIT_BCOND_EN
                    if (bcond_taken_s) begin
                        pcsel_s = 1'b1; k_s = sext19(ir_r[23:5]); ps_s = PS_REL;
                    end else begin
                        ps_s = PS_INC;
                    end
`else
                    illegal_s = 1'b1; state_nxt_s = HALT;
`endif
                end else begin
                    case (op11_s)
                        OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_ADDS, OP_SUBS: begin
                            da_s = rd_s; sa_s = rn_s; sb_s = rm_s;
                            fs_s = rtype_fs(op11_s);
                            sl_s = (op11_s == OP_ADDS) || (op11_s == OP_SUBS);
                            regw_s = 1'b1; en_alu_s = 1'b1; ps_s = PS_INC;
                        end
                        OP_LSL, OP_LSR: begin
                            da_s = rd_s; sa_s = rn_s; selb_s = 1'b1;
                            k_s = {58'd0, ir_r[15:10]};
                            fs_s = (op11_s == OP_LSL) ? FS_LSL : FS_LSR;
                            regw_s = 1'b1; en_alu_s = 1'b1; ps_s = PS_INC;
                        end
                        OP_STUR: begin
                            sa_s = rn_s; sb_s = rd_s; selb_s = 1'b1;
                            k_s = sext9(ir_r[20:12]); fs_s = FS_ADD;
                            ramw_s = 1'b1; ps_s = PS_INC;
                        end
                        OP_LDUR: begin
                            sa_s = rn_s; selb_s = 1'b1;
                            k_s = sext9(ir_r[20:12]); fs_s = FS_ADD;
                            state_nxt_s = (LOAD_CYCLES > 1) ? LOAD_WAIT : WB;
                        end
                        OP_BR: begin
                            sa_s = rn_s; ps_s = PS_LOAD;
                        end
                        default: begin
                            case (op10_s)
                                OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI, OP_EORI: begin
                                    da_s = rd_s; sa_s = rn_s; selb_s = 1'b1;
                                    k_s = {52'd0, ir_r[21:10]};
                                    fs_s = itype_fs(op10_s);
                                    regw_s = 1'b1; en_alu_s = 1'b1; ps_s = PS_INC;
                                end
                                default: begin
                                    illegal_s = 1'b1; state_nxt_s = HALT;
                                end
                            endcase
                        end
                    endcase
                end
            end
            LOAD_WAIT, WB: begin
                // Address path stays stable while memory data is awaited
                sa_s = rn_s; selb_s = 1'b1;
                k_s = sext9(ir_r[20:12]); fs_s = FS_ADD;
                if (state_r == WB) begin
                    da_s = rd_s; en_mem_s = 1'b1; regw_s = 1'b1; ps_s = PS_INC;
                    state_nxt_s = FETCH;
                end else if (int'(wait_r) >= LOAD_CYCLES - 2) begin
                    state_nxt_s = WB;
                end else begin
                    state_nxt_s = LOAD_WAIT;
                end
            end
            HALT:    state_nxt_s = HALT;
            default: state_nxt_s = FETCH;
        endcase
    end

    // Pack the control word; reset silences every output in its own cycle
    always_comb begin
        cw_s = 31'd0;
        cw_s[CW_PS +: 2]  = ps_s;
        cw_s[CW_DA +: 5]  = da_s;
        cw_s[CW_SA +: 5]  = sa_s;
        cw_s[CW_SB +: 5]  = sb_s;
        cw_s[CW_FS +: 5]  = fs_s;
        cw_s[CW_REGW]     = regw_s;
        cw_s[CW_RAMW]     = ramw_s;
        cw_s[CW_EN_MEM]   = en_mem_s;
        cw_s[CW_EN_ALU]   = en_alu_s;
        cw_s[CW_EN_B]     = 1'b0;
        cw_s[CW_EN_PC]    = en_pc_s;
        cw_s[CW_SELB]     = selb_s;
        cw_s[CW_PCSEL]    = pcsel_s;
        cw_s[CW_SL]       = sl_s;
        if (reset) begin
            controlWord = 31'd0;
            K           = 64'd0;
            halted      = 1'b0;
            illegal     = 1'b0;
        end else begin
            controlWord = cw_s;
            K           = k_s;
            halted      = (state_r == HALT);
            illegal     = illegal_s;
        end
    end
endmodule
